calc_entry_fsm: RTL and testbench

Operand-entry controller for the FPGA calculator, directly downstream of the keypad scanner (`keyboard`) on the same clock. It turns each decoded key event into calculator state:
- digits shift into BCD operand A or B;
- an operator key latches the operation;
- `=` issues a req/ack request to the arithmetic stage, and the returned result is captured.

It also drives the value the display stage shows.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/btn_edge.sv | 28 ++
 rtl/calc_entry_fsm.sv | 145 ++++++++++++++
 tb/tb_calc_entry_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: FSM state encoding,
// operator codes and default operand length.
package calc_pkg;

    localparam int NDIG_DEF = 4;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_REQ  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    function automatic logic is_bcd(input logic [3:0] v);
        return v <= 4'd9;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Key-down rising-edge detector, one-cycle key_evt.
// Ports: clk, rst_n, btn_press in; key_evt out.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_press,
    output logic key_evt
);

    logic prev;
    logic armed;

    // armed stays low until the key has been seen released
    // after reset, so a key held through reset is not an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= btn_press;
            if (!btn_press)
                armed <= 1'b1;
        end
    end

    assign key_evt = btn_press & ~prev & armed;

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator operand-entry FSM: builds BCD operands, latches
// the operator, handshakes with the arithmetic stage.
// Ports: key flags/values and calc_ack/result_bcd in;
// operand_a/b, op_code, calc_req, disp_bcd, state out.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_press,
    input  logic              is_num,
    input  logic              is_op,
    input  logic              is_eq,
    input  logic [3:0]        num_val,
    input  logic [1:0]        op_val,
    input  logic              calc_ack,
    input  logic [NDIG*4-1:0] result_bcd,
    output logic [NDIG*4-1:0] operand_a,
    output logic [NDIG*4-1:0] operand_b,
    output logic [1:0]        op_code,
    output logic              calc_req,
    output logic [NDIG*4-1:0] disp_bcd,
    output logic [2:0]        state
);

    localparam int W  = NDIG * 4;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] FULL = CW'(NDIG);

    logic          key_evt;
    logic          ev_eq, ev_op, ev_num;
    state_t        st, st_n;
    logic [W-1:0]  a_n, b_n, res, res_n;
    logic [1:0]    op_n;
    logic [CW-1:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n;
    logic [W-1:0]  digit;

    btn_edge u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_press (btn_press),
        .key_evt   (key_evt)
    );

    assign ev_eq  = key_evt & is_eq;
    assign ev_op  = key_evt & ~is_eq & is_op;
    assign ev_num = key_evt & ~is_eq & ~is_op
                  & is_num & is_bcd(num_val);
    assign digit  = {{(W-4){1'b0}}, num_val};

    always_comb begin
        st_n    = st;
        a_n     = operand_a;
        b_n     = operand_b;
        res_n   = res;
        op_n    = op_code;
        cnt_a_n = cnt_a;
        cnt_b_n = cnt_b;
        case (st)
            S_A: begin
                if (ev_op) begin
                    op_n = op_val;
                    st_n = S_OP;
                end else if (ev_num && cnt_a < FULL) begin
                    a_n     = (operand_a << 4) | digit;
                    cnt_a_n = cnt_a + CW'(1);
                end
            end
            S_OP: begin
                if (ev_op) begin
                    op_n = op_val;
                end else if (ev_num) begin
                    b_n     = digit;
                    cnt_b_n = CW'(1);
                    st_n    = S_B;
                end
            end
            S_B: begin
                if (ev_eq) begin
                    st_n = S_REQ;
                end else if (ev_num && cnt_b < FULL) begin
                    b_n     = (operand_b << 4) | digit;
                    cnt_b_n = cnt_b + CW'(1);
                end
            end
            S_REQ: begin
                if (calc_ack) begin
                    res_n = result_bcd;
                    st_n  = S_DONE;
                end
            end
            S_DONE: begin
                if (ev_op) begin
                    // chain: the result becomes operand A
                    a_n     = res;
                    cnt_a_n = FULL;
                    b_n     = '0;
                    cnt_b_n = '0;
                    op_n    = op_val;
                    st_n    = S_OP;
                end else if (ev_num) begin
                    a_n     = digit;
                    cnt_a_n = CW'(1);
                    b_n     = '0;
                    cnt_b_n = '0;
                    st_n    = S_A;
                end
            end
            default: st_n = S_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_A;
            operand_a <= '0;
            operand_b <= '0;
            res       <= '0;
            op_code   <= OP_ADD;
            cnt_a     <= '0;
            cnt_b     <= '0;
            calc_req  <= 1'b0;
            disp_bcd  <= '0;
        end else begin
            st        <= st_n;
            operand_a <= a_n;
            operand_b <= b_n;
            res       <= res_n;
            op_code   <= op_n;
            cnt_a     <= cnt_a_n;
            cnt_b     <= cnt_b_n;
            calc_req  <= (st_n == S_REQ);
            case (st_n)
                S_A, S_OP:  disp_bcd <= a_n;
                S_B, S_REQ: disp_bcd <= b_n;
                default:    disp_bcd <= res_n;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm: stimulus pushes
// expected snapshots, a negedge monitor pops and compares.
module tb_calc_entry_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_press = 1'b0;
    logic        is_num = 1'b0;
    logic        is_op = 1'b0;
    logic        is_eq = 1'b0;
    logic [3:0]  num_val = 4'd0;
    logic [1:0]  op_val = 2'd0;
    logic        calc_ack = 1'b0;
    logic [15:0] result_bcd = 16'h0;
    logic [15:0] operand_a, operand_b, disp_bcd;
    logic [1:0]  op_code;
    logic        calc_req;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          tag;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        req;
        logic [15:0] disp;
        logic [2:0]  st;
    } exp_t;

    exp_t q[$];

    calc_entry_fsm #(.NDIG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_press  (btn_press),
        .is_num     (is_num),
        .is_op      (is_op),
        .is_eq      (is_eq),
        .num_val    (num_val),
        .op_val     (op_val),
        .calc_ack   (calc_ack),
        .result_bcd (result_bcd),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op_code    (op_code),
        .calc_req   (calc_req),
        .disp_bcd   (disp_bcd),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (operand_a !== e.a || operand_b !== e.b ||
                op_code !== e.op || calc_req !== e.req ||
                disp_bcd !== e.disp || state !== e.st) begin
                failures++;
                $display("FAIL step%0d got a=%h b=%h op=%b req=%b disp=%h st=%0d want a=%h b=%h op=%b req=%b disp=%h st=%0d",
                    e.tag, operand_a, operand_b, op_code,
                    calc_req, disp_bcd, state, e.a, e.b,
                    e.op, e.req, e.disp, e.st);
            end
        end
    end

    task automatic expect_o(input int tag,
                            input logic [15:0] a,
                            input logic [15:0] b,
                            input logic [1:0] op,
                            input logic req,
                            input logic [15:0] disp,
                            input logic [2:0] st);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.op = op;
        e.req = req; e.disp = disp; e.st = st;
        q.push_back(e);
    endtask

    task automatic key(input logic n, input logic o,
                       input logic e, input logic [3:0] nv,
                       input logic [1:0] ov, input int hold);
        @(negedge clk);
        is_num = n; is_op = o; is_eq = e;
        num_val = nv; op_val = ov; btn_press = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        btn_press = 1'b0;
        is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic dig(input logic [3:0] v);
        key(1'b1, 1'b0, 1'b0, v, 2'd0, 1);
    endtask

    task automatic opk(input logic [1:0] v);
        key(1'b0, 1'b1, 1'b0, 4'd0, v, 1);
    endtask

    task automatic eqk();
        key(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1);
    endtask

    task automatic ack(input logic [15:0] r,
                       input logic with_key);
        int n;
        n = 0;
        while (calc_req !== 1'b1 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL req_wait got calc_req=%b want 1",
                     calc_req);
        end
        @(negedge clk);
        calc_ack = 1'b1; result_bcd = r;
        if (with_key) begin
            is_num = 1'b1; num_val = 4'd7; btn_press = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        calc_ack = 1'b0; btn_press = 1'b0; is_num = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_o(0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 3'd0);
        eqk();
        expect_o(1, 16'h0, 16'h0, 2'b00, 0, 16'h0, 3'd0);
        dig(4'd1);
        expect_o(2, 16'h1, 16'h0, 2'b00, 0, 16'h1, 3'd0);
        dig(4'd2);
        expect_o(3, 16'h12, 16'h0, 2'b00, 0, 16'h12, 3'd0);
        opk(2'b00);
        expect_o(4, 16'h12, 16'h0, 2'b00, 0, 16'h12, 3'd1);
        dig(4'd3);
        expect_o(5, 16'h12, 16'h3, 2'b00, 0, 16'h3, 3'd2);
        eqk();
        expect_o(6, 16'h12, 16'h3, 2'b00, 1, 16'h3, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        expect_o(7, 16'h12, 16'h3, 2'b00, 1, 16'h3, 3'd3);
        ack(16'h0015, 1'b0);
        expect_o(8, 16'h12, 16'h3, 2'b00, 0, 16'h15, 3'd4);
        eqk();
        expect_o(9, 16'h12, 16'h3, 2'b00, 0, 16'h15, 3'd4);
        opk(2'b10);
        expect_o(10, 16'h15, 16'h0, 2'b10, 0, 16'h15, 3'd1);
        dig(4'd2);
        expect_o(11, 16'h15, 16'h2, 2'b10, 0, 16'h2, 3'd2);
        eqk();
        expect_o(12, 16'h15, 16'h2, 2'b10, 1, 16'h2, 3'd3);
        dig(4'd7);
        opk(2'b01);
        expect_o(13, 16'h15, 16'h2, 2'b10, 1, 16'h2, 3'd3);
        ack(16'h0030, 1'b1);
        expect_o(14, 16'h15, 16'h2, 2'b10, 0, 16'h30, 3'd4);
        dig(4'd9);
        expect_o(15, 16'h9, 16'h0, 2'b10, 0, 16'h9, 3'd0);
        dig(4'd8);
        dig(4'd7);
        dig(4'd6);
        expect_o(16, 16'h9876, 16'h0, 2'b10, 0, 16'h9876, 3'd0);
        dig(4'd5);
        expect_o(17, 16'h9876, 16'h0, 2'b10, 0, 16'h9876, 3'd0);
        opk(2'b01);
        expect_o(18, 16'h9876, 16'h0, 2'b01, 0, 16'h9876, 3'd1);
        opk(2'b11);
        expect_o(19, 16'h9876, 16'h0, 2'b11, 0, 16'h9876, 3'd1);
        dig(4'd4);
        expect_o(20, 16'h9876, 16'h4, 2'b11, 0, 16'h4, 3'd2);
        key(1'b1, 1'b0, 1'b0, 4'd5, 2'd0, 20);
        expect_o(21, 16'h9876, 16'h45, 2'b11, 0, 16'h45, 3'd2);
        dig(4'd12);
        expect_o(22, 16'h9876, 16'h45, 2'b11, 0, 16'h45, 3'd2);
        opk(2'b00);
        expect_o(23, 16'h9876, 16'h45, 2'b11, 0, 16'h45, 3'd2);
        eqk();
        expect_o(24, 16'h9876, 16'h45, 2'b11, 1, 16'h45, 3'd3);
        dig(4'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expect_o(25, 16'h0, 16'h0, 2'b00, 0, 16'h0, 3'd0);
        dig(4'd3);
        opk(2'b10);
        @(negedge clk);
        btn_press = 1'b1; is_num = 1'b1; num_val = 4'd3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_o(26, 16'h0, 16'h0, 2'b00, 0, 16'h0, 3'd0);
        @(negedge clk);
        btn_press = 1'b0; is_num = 1'b0;
        @(posedge clk);
        key(1'b1, 1'b1, 1'b0, 4'd7, 2'b11, 1);
        expect_o(27, 16'h0, 16'h0, 2'b11, 0, 16'h0, 3'd1);
        eqk();
        expect_o(28, 16'h0, 16'h0, 2'b11, 0, 16'h0, 3'd1);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
